// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared FSM state encoding and credit-counter width helper
//                for the memory read requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counters must represent the full value DEPTH, hence one extra bit.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rsp_fifo
//  Description : Synchronous response FIFO with full/empty/count and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rsp_fifo import mem_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_flush,
    input  logic                           i_wr_en,
    input  logic [WIDTH-1:0]               i_wr_data,
    input  logic                           i_rd_en,
    output logic [WIDTH-1:0]               o_rd_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [credit_width(DEPTH)-1:0] o_count
);

    localparam int CNT_W = credit_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;
    // Head is masked when empty so the stream output reads zero after reset.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/mem_read_requester.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_requester
//  Description : Credit-limited burst read requester streaming responses out.
//                Optional abort input enabled by MEM_READ_REQUESTER_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_read_requester import mem_pkg::*; #(
    parameter int ADDRESS_WIDTH = 25,
    parameter int DATA_WIDTH    = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int BUF_DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] req_address,
    output logic                     req_wr,
    output logic [DATA_WIDTH-1:0]    req_data,
    output logic                     req_valid,
    input  logic                     req_full,
    input  logic [DATA_WIDTH-1:0]    rsp_data,
    input  logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef MEM_READ_REQUESTER_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int CNT_W = credit_width(BUF_DEPTH);
    localparam logic [CNT_W:0] c_depth = (CNT_W+1)'(BUF_DEPTH);

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]     r_remaining;
    logic [CNT_W-1:0]         r_outstanding;
    logic [CNT_W-1:0]         w_fifo_count;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_active;
    logic                     w_rsp_in;
    logic                     w_credit_ok;
    logic                     w_accept;
    logic                     w_fifo_wr;
    logic                     w_fifo_rd;
    logic                     w_abort;
    logic                     w_aborting;

    assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign w_rsp_in    = rsp_valid && w_active;
    // Requests in flight plus words held never exceed the buffer depth.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < c_depth;
    assign req_valid   = (r_state == ST_ISSUE) && !w_fifo_full && w_credit_ok && !w_abort;
    assign w_accept    = req_valid && !req_full;
    assign w_fifo_wr   = w_rsp_in && !w_aborting && !w_abort;
    assign w_fifo_rd   = out_valid && out_ready;
    assign out_valid   = !w_fifo_empty;
    assign req_address = r_addr;
    assign req_wr      = 1'b0;
    assign req_data    = '0;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef MEM_READ_REQUESTER_ABORT_EN
    logic r_aborting;

    assign w_abort    = abort && w_active;
    assign w_aborting = r_aborting;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aborting <= 1'b0;
        end else if (w_abort) begin
            r_aborting <= 1'b1;
        end else if (r_state == ST_DONE) begin
            r_aborting <= 1'b0;
        end
    end
`else
    assign w_abort    = 1'b0;
    assign w_aborting = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
        end else begin
            r_done <= 1'b0;
            case ({w_accept, w_rsp_in})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_accept) begin
                r_addr      <= r_addr + ADDRESS_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= length;
                        if (length == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_abort || (w_accept && r_remaining == LEN_WIDTH'(1))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0 && w_fifo_empty && !w_abort) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    mem_rsp_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_flush   (w_abort),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (rsp_data),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (out_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

endmodule
`default_nettype wire
